// File: rtl/cmd_frame_pkg.sv
// Shared state encoding, error codes and default frame constants for the command decoder.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package cmd_frame_pkg;

  // One-hot decoder states.
  typedef enum logic [4:0] {
    ST_HUNT  = 5'b00001,
    ST_HDR1  = 5'b00010,
    ST_BODY  = 5'b00100,
    ST_CHECK = 5'b01000,
    ST_OUT   = 5'b10000
  } state_e;

  // Error causes reported on err_code.
  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_BAD_HDR = 3'd1;
  localparam logic [2:0] ERR_BAD_SUM = 3'd2;
  localparam logic [2:0] ERR_BAD_TRL = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

  // Default framing bytes and board identity.
  localparam logic [7:0] DEF_HDR0     = 8'hEB;
  localparam logic [7:0] DEF_HDR1     = 8'h90;
  localparam logic [7:0] DEF_TRL0     = 8'h09;
  localparam logic [7:0] DEF_TRL1     = 8'hD7;
  localparam logic [7:0] DEF_BOARD_ID = 8'hAB;

endpackage

// File: rtl/cmd_gap_timer.sv
// Down-counter that flags expiry after CYCLES enabled cycles following a load.
// Latency: expire is combinational from the count; it rises in the CYCLES-th enabled cycle after load.
// Backpressure: none; clr dominates load, load dominates counting.
module cmd_gap_timer #(
  parameter int unsigned CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int unsigned   W        = $clog2(CYCLES + 1);
  localparam logic [W-1:0]  LOAD_VAL = W'(CYCLES);
  localparam logic [W-1:0]  ONE      = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  // Idle at zero, reload on activity, otherwise run down towards zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Last enabled cycle of the window; the caller decides whether activity overrides it.
  assign expire = en && (cnt_q == ONE);

endmodule

// File: rtl/cmd_frame_decoder.sv
// Hunts for framed commands in a byte stream, validates trailer/checksum/ID and emits the command.
// Latency: last frame byte accepted in cycle N gives cmd_valid from cycle N+2.
// Backpressure: rx_ready drops during the check cycle and while a command waits for cmd_ready.
module cmd_frame_decoder
  import cmd_frame_pkg::*;
#(
  parameter int unsigned FRAME_LEN  = 8,
  parameter logic [7:0]  HDR0       = DEF_HDR0,
  parameter logic [7:0]  HDR1       = DEF_HDR1,
  parameter logic [7:0]  TRL0       = DEF_TRL0,
  parameter logic [7:0]  TRL1       = DEF_TRL1,
  parameter logic [7:0]  BOARD_ID   = DEF_BOARD_ID,
  parameter int unsigned GAP_CYCLES = 1000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  output logic                        rx_ready,
  output logic                        cmd_valid,
  input  logic                        cmd_ready,
  output logic [7:0]                  cmd_opcode,
  output logic [(FRAME_LEN-6)*8-1:0]  cmd_arg,
  output logic                        err_valid,
  output logic [2:0]                  err_code,
  output logic [CNT_W-1:0]            frame_cnt,
  output logic [CNT_W-1:0]            err_cnt,
  output logic                        busy,
  input  logic                        clr_cnt
);

  localparam int unsigned      ARG_W    = (FRAME_LEN - 6) * 8;
  localparam int unsigned      BODY_W   = (FRAME_LEN - 3) * 8;  // frame bytes 3..FRAME_LEN-1
  localparam int unsigned      IDX_W    = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_FST  = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_SUM  = IDX_W'(FRAME_LEN - 3);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         sum_q, sum_d;
  logic [BODY_W-1:0]  body_q, body_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic [7:0]         cmd_opcode_q, cmd_opcode_d;
  logic [ARG_W-1:0]   cmd_arg_q, cmd_arg_d;
  logic               err_valid_q, err_valid_d;
  logic [2:0]         err_code_q, err_code_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic               rx_fire, frame_inc, gap_en, gap_clr, gap_expire, timeout;
  logic [7:0]         f_id, f_op, f_trl0, f_trl1;
  logic [ARG_W-1:0]   f_arg;

  assign rx_ready = (state_q == ST_HUNT) || (state_q == ST_HDR1) || (state_q == ST_BODY);
  assign rx_fire  = rx_valid && rx_ready;
  assign busy     = (state_q != ST_HUNT);

  // Body bytes shift in from the top, so after the last byte byte 3 sits in the LSBs.
  assign f_id   = body_q[7:0];
  assign f_op   = body_q[15:8];
  assign f_trl0 = body_q[BODY_W-9 -: 8];
  assign f_trl1 = body_q[BODY_W-1 -: 8];

  // Argument bytes 5..FRAME_LEN-3 packed from the LSB; the port has one spare top byte kept zero.
  always_comb begin
    f_arg = '0;
    for (int i = 0; i < int'(FRAME_LEN) - 7; i++) begin
      f_arg[i*8 +: 8] = body_q[16 + i*8 +: 8];
    end
  end

  // The gap window runs only while a frame is partially received.
  assign gap_en  = (state_q == ST_HDR1) || (state_q == ST_BODY);
  assign gap_clr = !((state_d == ST_HDR1) || (state_d == ST_BODY));
  assign timeout = gap_expire && !rx_fire;

  cmd_gap_timer #(
    .CYCLES (GAP_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (gap_clr),
    .load   (rx_fire),
    .en     (gap_en),
    .expire (gap_expire)
  );

  // Frame FSM: header hunt, body capture, one-cycle check, command hold.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    sum_d        = sum_q;
    body_d       = body_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_opcode_d = cmd_opcode_q;
    cmd_arg_d    = cmd_arg_q;
    err_valid_d  = 1'b0;
    err_code_d   = ERR_NONE;
    frame_inc    = 1'b0;
    case (state_q)
      ST_HUNT: begin
        if (rx_fire && (rx_data == HDR0)) state_d = ST_HDR1;
      end
      ST_HDR1: begin
        if (rx_fire) begin
          if (rx_data == HDR1) begin
            state_d = ST_BODY;
            idx_d   = IDX_FST;
            sum_d   = 8'h00;
          end else if (rx_data != HDR0) begin
            state_d     = ST_HUNT;
            err_valid_d = 1'b1;
            err_code_d  = ERR_BAD_HDR;
          end
        end else if (timeout) begin
          state_d     = ST_HUNT;
          err_valid_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
        end
      end
      ST_BODY: begin
        if (rx_fire) begin
          body_d = {rx_data, body_q[BODY_W-1:8]};
          if (idx_q <= IDX_SUM) sum_d = sum_q + rx_data;
          idx_d = idx_q + IDX_ONE;
          if (idx_q == IDX_LAST) state_d = ST_CHECK;
        end else if (timeout) begin
          state_d     = ST_HUNT;
          err_valid_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
        end
      end
      ST_CHECK: begin
        state_d = ST_HUNT;
        if ((f_trl0 != TRL0) || (f_trl1 != TRL1)) begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_BAD_TRL;
        end else if (sum_q != 8'h00) begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_BAD_SUM;
        end else if (f_id == BOARD_ID) begin
          state_d      = ST_OUT;
          cmd_valid_d  = 1'b1;
          cmd_opcode_d = f_op;
          cmd_arg_d    = f_arg;
          frame_inc    = 1'b1;
        end
      end
      ST_OUT: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = ST_HUNT;
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  // Saturating statistics; a clear wins over a same-cycle increment.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (clr_cnt) begin
      frame_cnt_d = '0;
      err_cnt_d   = '0;
    end else begin
      if (frame_inc && (frame_cnt_q != '1)) frame_cnt_d = frame_cnt_q + CNT_ONE;
      if (err_valid_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_ONE;
    end
  end

  // State and output registers; reset drops any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HUNT;
      idx_q        <= '0;
      sum_q        <= '0;
      body_q       <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_opcode_q <= '0;
      cmd_arg_q    <= '0;
      err_valid_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      sum_q        <= sum_d;
      body_q       <= body_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_opcode_q <= cmd_opcode_d;
      cmd_arg_q    <= cmd_arg_d;
      err_valid_q  <= err_valid_d;
      err_code_q   <= err_code_d;
      frame_cnt_q  <= frame_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_opcode = cmd_opcode_q;
  assign cmd_arg    = cmd_arg_q;
  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;
  assign frame_cnt  = frame_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: doc/cmd_frame_decoder.md
Name: cmd_frame_decoder

Overview:
- Parametrised, stream-based successor to the switch-board command recogniser.
- Accepts a byte stream from the UART receive path and hunts for header bytes. It collects a FRAME_LEN-byte frame, then checks the trailer, the zero-sum checksum and the board ID.
- A good frame is presented as a decoded command through a valid/ready handshake to the switch/reset/power control logic.
- Adds functions the previous block lacked: inter-byte timeout, header resync, error codes with counters, and output back-pressure.

Parameters:
- FRAME_LEN, 8, total frame bytes; legal range 7..16.
- HDR0, 8'hEB, first header byte.
- HDR1, 8'h90, second header byte.
- TRL0, 8'h09, first trailer byte (frame byte FRAME_LEN-2).
- TRL1, 8'hD7, second trailer byte (frame byte FRAME_LEN-1).
- BOARD_ID, 8'hAB, accepted board ID (frame byte 3).
- GAP_CYCLES, 1000, maximum clk cycles allowed between bytes inside a frame.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- rx_data, in, 8, received byte.
- rx_valid, in, 1, rx_data is valid.
- rx_ready, out, 1, decoder accepts a byte; a byte transfers when rx_valid&rx_ready.
- cmd_valid, out, 1, decoded command available.
- cmd_ready, in, 1, consumer takes the command.
- cmd_opcode, out, 8, frame byte 4.
- cmd_arg, out, (FRAME_LEN-6)*8, frame bytes 5..FRAME_LEN-3; byte 5 in the LSBs.
- err_valid, out, 1, one-cycle error strobe.
- err_code, out, 3, error cause; valid while err_valid is high.
- frame_cnt, out, CNT_W, count of good frames for this board.
- err_cnt, out, CNT_W, count of error events.
- busy, out, 1, high whenever the state is not HUNT.
- clr_cnt, in, 1, synchronous clear of both counters.

Behaviour:
- Reset values: state HUNT, rx_ready=1, cmd_valid=0, cmd_opcode=0, cmd_arg=0, err_valid=0, err_code=0, counters=0, busy=0. Reset mid-frame discards any partial frame.
- Frame layout:
  - byte0 = HDR0, byte1 = HDR1.
  - byte2 = checksum, byte3 = ID, byte4 = opcode, bytes 5..FRAME_LEN-3 = arguments.
  - Last two bytes = TRL0, TRL1.
  - Checksum rule: the mod-256 sum of bytes 2..FRAME_LEN-3 must equal 0.
- States:
  - HUNT: a byte equal to HDR0 moves to HDR1; any other byte is dropped silently (no error).
  - HDR1: a byte equal to HDR1 moves to BODY with byte_idx=2. A byte equal to HDR0 stays in HDR1 (resync). Any other byte raises error BAD_HDR (1) and returns to HUNT.
  - BODY: stores each byte at byte_idx and increments byte_idx. The byte stored at FRAME_LEN-1 moves to CHECK.
  - CHECK: lasts one cycle, rx_ready=0. Evaluation priority:
    - Trailer mismatch: BAD_TRL (3), go to HUNT.
    - Otherwise checksum nonzero: BAD_SUM (2), go to HUNT.
    - Otherwise ID != BOARD_ID: discard silently, go to HUNT.
    - Otherwise load cmd_opcode and cmd_arg, set cmd_valid=1, increment frame_cnt, go to OUT.
  - OUT: rx_ready=0; cmd_valid and the cmd fields are held stable until cmd_ready. On handshake, cmd_valid=0 next cycle and the state returns to HUNT with rx_ready=1.
- Latency: the last byte accepted in cycle N gives cmd_valid high from cycle N+2.
- The checksum is accumulated running as bytes arrive (8-bit wrap), not summed in CHECK.
- Timeout:
  - gap counter clears on every accepted byte and counts cycles without a byte while in HDR1 or BODY.
  - When it reaches GAP_CYCLES with no byte in that cycle, raise TIMEOUT (4) and go to HUNT.
  - A byte accepted in the expiry cycle wins: no timeout, and the byte is processed.
  - The counter is idle and held at 0 in HUNT, CHECK and OUT.
- Errors: err_valid pulses for exactly one cycle per event with the matching err_code, and err_cnt increments on that pulse.
- Counters: both saturate at all-ones. clr_cnt takes priority over an increment in the same cycle.
- rx_ready is high in HUNT, HDR1 and BODY.

Decomposition:
- Shared package cmd_frame_pkg holds:
  - state encoding (one-hot HUNT/HDR1/BODY/CHECK/OUT);
  - error codes ERR_NONE=0, ERR_BAD_HDR=1, ERR_BAD_SUM=2, ERR_BAD_TRL=3, ERR_TIMEOUT=4;
  - default header, trailer and board-ID constants.
- One sub-module, cmd_gap_timer: a parametrised down-counter with clear, enable and expire outputs, reused later for reset-pulse timing.

Test Plan:
- Good frame EB 90 0B AB 0A 40 09 D7, cmd_ready=1: cmd_valid for 1 cycle at N+2 with opcode=0A, arg=40; frame_cnt=1, err_valid never asserted.
- Same frame but byte2=0C: err_valid with err_code=2, err_cnt=1, no cmd_valid, and the next good frame decodes normally.
- Stream 55 EB EB 90 + good body: the leading 55 is dropped, the double EB resyncs, and the command decodes (no error).
- Frame with ID=AC (checksum adjusted to 0A): no cmd_valid, no err_valid, counters unchanged.
- GAP_CYCLES=16, stall 16 cycles after byte 4: err_code=4, state HUNT. A byte arriving on exactly the expiry cycle suppresses the timeout.
- Two back-to-back good frames with cmd_ready low for 20 cycles: rx_ready=0 during hold, cmd fields stable, the second frame accepted after the handshake. Then assert rst_n low mid-frame, release, and a fresh frame decodes.
